// File: rtl/cpu15_pkg.sv
// Shared CPU15 defaults: datapath widths, register-index type and the onehot
// decode helper used by the register-read stage.
package cpu15_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_REGS = 8;
    localparam int DEF_REG_AW = $clog2(DEF_N_REGS);

    typedef logic [DEF_REG_AW-1:0] reg_idx_t;

    // One bit of onehot(idx) gated by en, evaluated at bit position pos.
    function automatic logic onehot_bit(input logic en, input logic [31:0] idx, input int pos);
        return en && (idx == 32'(pos));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by a newly
// issued writer, cleared by write-back or by flushing the held writer.
module reg_scoreboard
    import cpu15_pkg::*;
#(
    parameter  int N_REGS = DEF_N_REGS,
    localparam int REG_AW = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic              fl_en,
    input  logic [REG_AW-1:0] fl_idx,
    input  logic [REG_AW-1:0] rd_a_idx,
    input  logic [REG_AW-1:0] rd_b_idx,
    output logic              pend_a,
    output logic              pend_b
);

    logic [N_REGS-1:0] pend_q;
    logic [N_REGS-1:0] pend_d;

    // A set on the same index as a clear wins: the new writer is younger.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_REGS; i++) begin
            pend_d[i] = onehot_bit(set_en, 32'(set_idx), i)
                      | (pend_q[i] & ~(onehot_bit(clr_en, 32'(clr_idx), i)
                                     | onehot_bit(fl_en, 32'(fl_idx), i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_a = pend_q[rd_a_idx];
    assign pend_b = pend_q[rd_b_idx];

endmodule

// File: rtl/reg_dc_sb.sv
// CPU15 register-read/decode stage: source reads with same-cycle write-back
// forwarding, RAW stall against the pending-write scoreboard, one output slot.
module reg_dc_sb
    import cpu15_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int N_REGS = DEF_N_REGS,
    localparam int REG_AW = $clog2(N_REGS)
) (
    input  logic                     CLK_DC,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [REG_AW-1:0]        N_REG_A_IN,
    input  logic [REG_AW-1:0]        N_REG_B_IN,
    input  logic                     USE_B_IN,
    input  logic [REG_AW-1:0]        N_DST_IN,
    input  logic                     DST_WE_IN,
    input  logic [N_REGS*DATA_W-1:0] REG_FILE,
    input  logic                     WB_WE,
    input  logic [REG_AW-1:0]        N_WB,
    input  logic [DATA_W-1:0]        WB_DATA,
    input  logic                     FLUSH,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [REG_AW-1:0]        N_REG_A_OUT,
    output logic [REG_AW-1:0]        N_REG_B_OUT,
    output logic [REG_AW-1:0]        N_DST_OUT,
    output logic                     DST_WE_OUT,
    output logic [DATA_W-1:0]        REG_A_OUT,
    output logic [DATA_W-1:0]        REG_B_OUT,
    output logic                     HAZARD
);

    logic [DATA_W-1:0] rf_p0 [N_REGS];
    logic              fwd_a_p0, fwd_b_p0;
    logic [DATA_W-1:0] rd_a_p0, rd_b_p0;
    logic              pend_a_p0, pend_b_p0;
    logic              hazard_p0, ready_p0, accept_p0;

    logic              vld_p1;
    logic [REG_AW-1:0] n_a_p1, n_b_p1, n_dst_p1;
    logic              dst_we_p1;
    logic [DATA_W-1:0] reg_a_p1, reg_b_p1;

    for (genvar g = 0; g < N_REGS; g++) begin : g_rf
        assign rf_p0[g] = REG_FILE[g*DATA_W +: DATA_W];
    end

    // ---- p0: read, forward, hazard and handshake (combinational) ----
    assign fwd_a_p0 = WB_WE && (N_WB == N_REG_A_IN);
    assign fwd_b_p0 = WB_WE && (N_WB == N_REG_B_IN);
    assign rd_a_p0  = fwd_a_p0 ? WB_DATA : rf_p0[N_REG_A_IN];
    assign rd_b_p0  = fwd_b_p0 ? WB_DATA : rf_p0[N_REG_B_IN];

    assign hazard_p0 = IN_VALID && ((pend_a_p0 && !fwd_a_p0)
                                 || (USE_B_IN && pend_b_p0 && !fwd_b_p0));
    assign ready_p0  = (!vld_p1 || OUT_READY) && !hazard_p0 && !FLUSH;
    assign accept_p0 = IN_VALID && ready_p0;

    reg_scoreboard #(.N_REGS(N_REGS)) u_sb (
        .clk      (CLK_DC),
        .rst      (RST),
        .set_en   (accept_p0 && DST_WE_IN),
        .set_idx  (N_DST_IN),
        .clr_en   (WB_WE),
        .clr_idx  (N_WB),
        .fl_en    (FLUSH && vld_p1 && dst_we_p1),
        .fl_idx   (n_dst_p1),
        .rd_a_idx (N_REG_A_IN),
        .rd_b_idx (N_REG_B_IN),
        .pend_a   (pend_a_p0),
        .pend_b   (pend_b_p0)
    );

    // ---- p1: output slot, held while execute stalls ----
    always_ff @(posedge CLK_DC or posedge RST) begin
        if (RST) begin
            vld_p1    <= 1'b0;
            n_a_p1    <= '0;
            n_b_p1    <= '0;
            n_dst_p1  <= '0;
            dst_we_p1 <= 1'b0;
            reg_a_p1  <= '0;
            reg_b_p1  <= '0;
        end else if (accept_p0) begin
            vld_p1    <= 1'b1;
            n_a_p1    <= N_REG_A_IN;
            n_b_p1    <= N_REG_B_IN;
            n_dst_p1  <= N_DST_IN;
            dst_we_p1 <= DST_WE_IN;
            reg_a_p1  <= rd_a_p0;
            reg_b_p1  <= rd_b_p0;
        end else if (FLUSH || OUT_READY) begin
            vld_p1    <= 1'b0;
        end
    end

    assign IN_READY    = ready_p0;
    assign HAZARD      = hazard_p0;
    assign OUT_VALID   = vld_p1;
    assign N_REG_A_OUT = n_a_p1;
    assign N_REG_B_OUT = n_b_p1;
    assign N_DST_OUT   = n_dst_p1;
    assign DST_WE_OUT  = dst_we_p1;
    assign REG_A_OUT   = reg_a_p1;
    assign REG_B_OUT   = reg_b_p1;

endmodule
